// File: rtl/axi3_ram_slave_pkg.sv
// Shared AXI3 definitions: burst/response encodings, request/response bundles and the burst address stepper.
// Combinational helpers only; no clocked state lives here.
package axi3_ram_slave_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_SLVERR = 2'b10
  } axi_resp_t;

  typedef struct packed {
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        rready;
  } axi3_rd_req_t;

  typedef struct packed {
    logic        arready;
    logic [31:0] rdata;
    axi_resp_t   rresp;
    logic        rlast;
    logic        rvalid;
  } axi3_rd_resp_t;

  typedef struct packed {
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
  } axi3_wr_req_t;

  typedef struct packed {
    logic      awready;
    logic      wready;
    axi_resp_t bresp;
    logic      bvalid;
  } axi3_wr_resp_t;

  function automatic logic axi_wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  function automatic logic axi_burst_err(input logic [1:0] burst, input logic [3:0] len);
    return (burst == 2'b11) || ((burst == AXI_BURST_WRAP) && !axi_wrap_len_ok(len));
  endfunction

  // Word-sized beats only; reserved bursts and bad WRAP lengths step like INCR.
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                                input logic [3:0] len);
    logic [31:0] incr;
    logic [31:0] mask;
    incr = addr + 32'd4;
    mask = {26'd0, len, 2'b11};
    if (burst == AXI_BURST_FIXED)
      return addr;
    else if ((burst == AXI_BURST_WRAP) && axi_wrap_len_ok(len))
      return (addr & ~mask) | (incr & mask);
    else
      return incr;
  endfunction

endpackage

// File: rtl/dual_port_bram.sv
// Word RAM: one synchronous read port, one byte-enabled write port; read-first on same-word collision.
// Read data appears the cycle after rd_en and holds while rd_en is low; no backpressure.
module dual_port_bram #(
  parameter int    WORDS     = 4096,
  parameter string INIT_FILE = "",
  localparam int   AW        = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_dat,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_dat
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (rd_en)
      rd_dat <= mem[rd_idx];
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i])
          mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/axi3_ram_slave.sv
// AXI3 RAM responder, one read and one write burst in flight; first rvalid 2 cycles after AR, 1 beat/cycle after.
// R beats hold while rready is low; B holds until bready; W is refused until AW has been taken.
module axi3_ram_slave
  import axi3_ram_slave_pkg::*;
#(
  parameter int    BUS_WIDTH = 4,
  parameter int    MEM_WORDS = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  axi3_rd_req_t         axi3_rd_req,
  input  logic [BUS_WIDTH-1:0] arid,
  output axi3_rd_resp_t        axi3_rd_resp,
  output logic [BUS_WIDTH-1:0] rid,
  input  axi3_wr_req_t         axi3_wr_req,
  input  logic [BUS_WIDTH-1:0] awid,
  input  logic [BUS_WIDTH-1:0] wid,
  output axi3_wr_resp_t        axi3_wr_resp,
  output logic [BUS_WIDTH-1:0] bid
);

  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // ---------------- read channel ----------------
  r_state_t             r_state_q, r_state_d;
  logic                 arready_q, rvalid_q;
  logic [31:0]          r_addr_q, r_addr_nxt;
  logic [3:0]           r_len_q, r_cnt_q;
  logic [1:0]           r_burst_q;
  logic                 r_err_q, r_size_err_q;
  logic [BUS_WIDTH-1:0] rid_q;
  logic                 ar_hs, rd_en, r_last;
  logic [IW-1:0]        rd_idx;
  logic [31:0]          rd_dat;

  assign r_addr_nxt = axi_next_addr(r_addr_q, r_burst_q, r_len_q);
  assign r_last     = (r_cnt_q == r_len_q);

  // The RAM output register doubles as the R data register: it only moves when the next beat is fetched.
  always_comb begin
    r_state_d = r_state_q;
    ar_hs     = 1'b0;
    rd_en     = 1'b0;
    rd_idx    = r_addr_q[2 +: IW];
    unique case (r_state_q)
      R_IDLE: begin
        if (arready_q && axi3_rd_req.arvalid) begin
          ar_hs     = 1'b1;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        rd_en     = 1'b1;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        if (axi3_rd_req.rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            rd_en  = 1'b1;
            rd_idx = r_addr_nxt[2 +: IW];
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q    <= R_IDLE;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      r_addr_q     <= '0;
      r_len_q      <= '0;
      r_cnt_q      <= '0;
      r_burst_q    <= '0;
      r_err_q      <= 1'b0;
      r_size_err_q <= 1'b0;
      rid_q        <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_DATA);
      if (ar_hs) begin
        r_addr_q     <= axi3_rd_req.araddr;
        r_len_q      <= axi3_rd_req.arlen;
        r_burst_q    <= axi3_rd_req.arburst;
        r_cnt_q      <= '0;
        rid_q        <= arid;
        r_size_err_q <= (axi3_rd_req.arsize != AXI_SIZE_WORD);
        r_err_q      <= axi_burst_err(axi3_rd_req.arburst, axi3_rd_req.arlen) ||
                        (axi3_rd_req.arsize != AXI_SIZE_WORD);
      end else if ((r_state_q == R_DATA) && axi3_rd_req.rready && !r_last) begin
        r_addr_q <= r_addr_nxt;
        r_cnt_q  <= r_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    axi3_rd_resp         = '0;
    axi3_rd_resp.arready = arready_q;
    axi3_rd_resp.rvalid  = rvalid_q;
    axi3_rd_resp.rdata   = (rvalid_q && !r_size_err_q) ? rd_dat : 32'd0;
    axi3_rd_resp.rresp   = (rvalid_q && r_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    axi3_rd_resp.rlast   = rvalid_q && r_last;
  end

  assign rid = rid_q;

  // ---------------- write channel ----------------
  w_state_t             w_state_q, w_state_d;
  logic                 awready_q, wready_q, bvalid_q;
  logic [31:0]          w_addr_q, w_addr_nxt;
  logic [3:0]           w_len_q, w_cnt_q;
  logic [1:0]           w_burst_q;
  logic                 w_err_q, w_size_err_q;
  logic [BUS_WIDTH-1:0] bid_q;
  logic                 aw_hs, w_hs, wr_en, w_last, w_id_ok;

  assign w_addr_nxt = axi_next_addr(w_addr_q, w_burst_q, w_len_q);
  assign w_last     = (w_cnt_q == w_len_q);
  assign w_hs       = wready_q && axi3_wr_req.wvalid;
  assign w_id_ok    = (wid == bid_q);

  always_comb begin
    w_state_d = w_state_q;
    aw_hs     = 1'b0;
    wr_en     = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (awready_q && axi3_wr_req.awvalid) begin
          aw_hs     = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          wr_en = !w_size_err_q && w_id_ok;
          if (w_last)
            w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi3_wr_req.bready)
          w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Beat count alone ends the burst; a disagreeing wlast or wid only poisons the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      w_addr_q     <= '0;
      w_len_q      <= '0;
      w_cnt_q      <= '0;
      w_burst_q    <= '0;
      w_err_q      <= 1'b0;
      w_size_err_q <= 1'b0;
      bid_q        <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_DATA);
      bvalid_q  <= (w_state_d == W_RESP);
      if (aw_hs) begin
        w_addr_q     <= axi3_wr_req.awaddr;
        w_len_q      <= axi3_wr_req.awlen;
        w_burst_q    <= axi3_wr_req.awburst;
        w_cnt_q      <= '0;
        bid_q        <= awid;
        w_size_err_q <= (axi3_wr_req.awsize != AXI_SIZE_WORD);
        w_err_q      <= axi_burst_err(axi3_wr_req.awburst, axi3_wr_req.awlen) ||
                        (axi3_wr_req.awsize != AXI_SIZE_WORD);
      end else if (w_hs) begin
        if (!w_last) begin
          w_addr_q <= w_addr_nxt;
          w_cnt_q  <= w_cnt_q + 4'd1;
        end
        if (!w_id_ok || (axi3_wr_req.wlast != w_last))
          w_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    axi3_wr_resp         = '0;
    axi3_wr_resp.awready = awready_q;
    axi3_wr_resp.wready  = wready_q;
    axi3_wr_resp.bvalid  = bvalid_q;
    axi3_wr_resp.bresp   = (bvalid_q && w_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  end

  assign bid = bid_q;

  logic unused_ok;
  assign unused_ok = ^{axi3_rd_req.arlock, axi3_rd_req.arcache, axi3_rd_req.arprot,
                       axi3_wr_req.awlock, axi3_wr_req.awcache, axi3_wr_req.awprot};

  dual_port_bram #(
    .WORDS     (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .rd_en  (rd_en),
    .rd_idx (rd_idx),
    .rd_dat (rd_dat),
    .wr_en  (wr_en),
    .wr_idx (w_addr_q[2 +: IW]),
    .wr_be  (axi3_wr_req.wstrb),
    .wr_dat (axi3_wr_req.wdata)
  );

endmodule
